// File: rtl/control_unit_mc.sv
// Multi-cycle opcode decoder/sequencer for the 8-bit CPU: registered controls, MULT and memory stalls.
// Optional `CU_BUSY_TIMEOUT_EN adds a BUSYWAIT timeout with a MEM_FAULT pulse.
module control_unit_mc #(
    parameter int OPCODE_W     = 8,
    parameter int MULT_CYCLES  = 3,
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [OPCODE_W-1:0] OPCODE,
    input  logic                INSTR_VALID,
    input  logic                BUSYWAIT,
    output logic                WRITEENABLE,
    output logic                ALUSRC,
    output logic [2:0]          ALUOP,
    output logic                NEMUX,
    output logic                SHDIR,
    output logic                BRANCH,
    output logic                BNE,
    output logic                JUMP,
    output logic                MEMREAD,
    output logic                MEMWRITE,
    output logic                MEM2REG,
    output logic                STALL,
    output logic                ILLEGAL
`ifdef CU_BUSY_TIMEOUT_EN
    ,
    output logic                MEM_FAULT
`endif
);
    typedef enum logic [1:0] {S_READY, S_MULT, S_MEM, S_WB} state_t;

    typedef struct packed {
        logic       we;
        logic       alusrc;
        logic [2:0] aluop;
        logic       nemux;
        logic       shdir;
        logic       branch;
        logic       bne;
        logic       jump;
        logic       memread;
        logic       memwrite;
        logic       mem2reg;
        logic       stall;
        logic       illegal;
    } ctl_t;

    localparam int CW = (MULT_CYCLES > 2) ? $clog2(MULT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MULT_CYCLES - 1);

    if (MULT_CYCLES < 1 || BUSY_TIMEOUT < 1) begin : g_bad_param
        $error("control_unit_mc: MULT_CYCLES and BUSY_TIMEOUT must be >= 1");
    end

    state_t        r_state, w_state_nxt;
    ctl_t          r_ctl, w_ctl_nxt, w_dec;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          w_legal, w_upper_ok, w_is_mem, w_is_mult;

    if (OPCODE_W > 8) begin : g_upper
        assign w_upper_ok = ~|OPCODE[OPCODE_W-1:8];
    end else begin : g_no_upper
        assign w_upper_ok = 1'b1;
    end

    always_comb begin
        w_dec     = '0;
        w_legal   = w_upper_ok;
        w_is_mult = 1'b0;
        case (OPCODE[7:0])
            8'h00: begin w_dec.we = 1'b1; w_dec.alusrc = 1'b1; w_dec.aluop = 3'b001; end
            8'h01: begin w_dec.we = 1'b1; w_dec.alusrc = 1'b1; w_dec.aluop = 3'b001; w_dec.nemux = 1'b1; end
            8'h02: begin w_dec.we = 1'b1; w_dec.alusrc = 1'b1; w_dec.aluop = 3'b010; end
            8'h03: begin w_dec.we = 1'b1; w_dec.alusrc = 1'b1; w_dec.aluop = 3'b011; end
            8'h04: begin w_dec.we = 1'b1; w_dec.alusrc = 1'b1; end
            8'h05: begin w_dec.we = 1'b1; end
            8'h06: begin w_dec.jump = 1'b1; end
            8'h07: begin w_dec.branch = 1'b1; w_dec.alusrc = 1'b1; w_dec.aluop = 3'b001; w_dec.nemux = 1'b1; end
            8'h08: begin w_dec.memread = 1'b1; w_dec.alusrc = 1'b1; end
            8'h09: begin w_dec.memread = 1'b1; end
            8'h0A: begin w_dec.memwrite = 1'b1; w_dec.alusrc = 1'b1; end
            8'h0B: begin w_dec.memwrite = 1'b1; end
            8'h0C: begin w_dec.we = 1'b1; w_dec.alusrc = 1'b1; w_dec.aluop = 3'b100; w_is_mult = 1'b1; end
            8'h0D: begin w_dec.bne = 1'b1; w_dec.alusrc = 1'b1; w_dec.aluop = 3'b001; w_dec.nemux = 1'b1; end
            8'h0E: begin w_dec.we = 1'b1; w_dec.aluop = 3'b101; end
            8'h0F: begin w_dec.we = 1'b1; w_dec.aluop = 3'b101; w_dec.shdir = 1'b1; end
            default: w_legal = 1'b0;
        endcase
        w_is_mem = w_dec.memread | w_dec.memwrite;
    end

`ifdef CU_BUSY_TIMEOUT_EN
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    logic [TW-1:0] r_tmo, w_tmo_nxt;
    logic          r_fault, w_fault_nxt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_ctl_nxt   = '0;
        w_cnt_nxt   = r_cnt;
`ifdef CU_BUSY_TIMEOUT_EN
        w_tmo_nxt   = r_tmo;
        w_fault_nxt = 1'b0;
`endif
        case (r_state)
            S_READY: begin
                if (INSTR_VALID) begin
                    if (!w_legal) begin
                        w_ctl_nxt.illegal = 1'b1;
                    end else begin
                        w_ctl_nxt = w_dec;
                        if (w_is_mult && (MULT_CYCLES > 1)) begin
                            w_ctl_nxt.we    = 1'b0;
                            w_ctl_nxt.stall = 1'b1;
                            w_cnt_nxt       = CNT_INIT;
                            w_state_nxt     = S_MULT;
                        end else if (w_is_mem) begin
                            w_ctl_nxt.stall = 1'b1;
                            w_state_nxt     = S_MEM;
`ifdef CU_BUSY_TIMEOUT_EN
                            w_tmo_nxt       = '0;
`endif
                        end
                    end
                end
            end
            S_MULT: begin
                w_ctl_nxt = r_ctl;
                w_cnt_nxt = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_ctl_nxt.we    = 1'b1;
                    w_ctl_nxt.stall = 1'b0;
                    w_state_nxt     = S_READY;
                end
            end
            S_MEM: begin
                if (BUSYWAIT) begin
                    w_ctl_nxt = r_ctl;
`ifdef CU_BUSY_TIMEOUT_EN
                    w_tmo_nxt = r_tmo + TW'(1);
                    if (r_tmo == TW'(BUSY_TIMEOUT - 1)) begin
                        w_ctl_nxt   = '0;
                        w_fault_nxt = 1'b1;
                        w_state_nxt = S_READY;
                    end
`endif
                end else if (r_ctl.memread) begin
                    w_ctl_nxt.we      = 1'b1;
                    w_ctl_nxt.mem2reg = 1'b1;
                    w_state_nxt       = S_WB;
                end else begin
                    w_state_nxt = S_READY;
                end
            end
            default: w_state_nxt = S_READY;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_READY;
            r_ctl   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ctl   <= w_ctl_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef CU_BUSY_TIMEOUT_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_tmo   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_tmo   <= w_tmo_nxt;
            r_fault <= w_fault_nxt;
        end
    end
    assign MEM_FAULT = r_fault;
`endif

    assign WRITEENABLE = r_ctl.we;
    assign ALUSRC      = r_ctl.alusrc;
    assign ALUOP       = r_ctl.aluop;
    assign NEMUX       = r_ctl.nemux;
    assign SHDIR       = r_ctl.shdir;
    assign BRANCH      = r_ctl.branch;
    assign BNE         = r_ctl.bne;
    assign JUMP        = r_ctl.jump;
    assign MEMREAD     = r_ctl.memread;
    assign MEMWRITE    = r_ctl.memwrite;
    assign MEM2REG     = r_ctl.mem2reg;
    assign STALL       = r_ctl.stall;
    assign ILLEGAL     = r_ctl.illegal;
endmodule

// File: tb/tb_control_unit_mc.sv
// Scoreboard bench for control_unit_mc: instructions expand into per-cycle expected control vectors.
module tb_control_unit_mc;
    localparam int OW = 10;
    localparam int MC = 3;
    localparam int BT = 8;

    typedef struct packed {
        logic       we;
        logic       alusrc;
        logic [2:0] aluop;
        logic       nemux;
        logic       shdir;
        logic       branch;
        logic       bne;
        logic       jump;
        logic       memread;
        logic       memwrite;
        logic       mem2reg;
        logic       stall;
        logic       illegal;
        logic       fault;
    } vec_t;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [OW-1:0] OPCODE;
    logic          INSTR_VALID, BUSYWAIT;
    logic          WRITEENABLE, ALUSRC, NEMUX, SHDIR, BRANCH, BNE, JUMP;
    logic          MEMREAD, MEMWRITE, MEM2REG, STALL, ILLEGAL;
    logic [2:0]    ALUOP;
    logic          fault_w;

    int   total = 0;
    int   bad   = 0;
    vec_t expq[$];

    control_unit_mc #(.OPCODE_W(OW), .MULT_CYCLES(MC), .BUSY_TIMEOUT(BT)) dut (
        .CLK(CLK), .RESET(RESET), .OPCODE(OPCODE), .INSTR_VALID(INSTR_VALID), .BUSYWAIT(BUSYWAIT),
        .WRITEENABLE(WRITEENABLE), .ALUSRC(ALUSRC), .ALUOP(ALUOP), .NEMUX(NEMUX), .SHDIR(SHDIR),
        .BRANCH(BRANCH), .BNE(BNE), .JUMP(JUMP), .MEMREAD(MEMREAD), .MEMWRITE(MEMWRITE),
        .MEM2REG(MEM2REG), .STALL(STALL), .ILLEGAL(ILLEGAL)
`ifdef CU_BUSY_TIMEOUT_EN
        , .MEM_FAULT(fault_w)
`endif
    );
`ifndef CU_BUSY_TIMEOUT_EN
    assign fault_w = 1'b0;
`endif

    always #5 CLK = ~CLK;

    function automatic vec_t actual();
        vec_t a;
        a = '{we: WRITEENABLE, alusrc: ALUSRC, aluop: ALUOP, nemux: NEMUX, shdir: SHDIR,
              branch: BRANCH, bne: BNE, jump: JUMP, memread: MEMREAD, memwrite: MEMWRITE,
              mem2reg: MEM2REG, stall: STALL, illegal: ILLEGAL, fault: fault_w};
        return a;
    endfunction

    task automatic chk(input string name, input vec_t got, input vec_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
        end
    endtask

    // Controls for the cycle after an opcode is accepted, straight from the opcode map.
    function automatic vec_t dec(input logic [OW-1:0] op);
        vec_t v;
        v = '0;
        if (op > 15) v.illegal = 1'b1;
        else case (op[3:0])
            0:  begin v.we = 1; v.alusrc = 1; v.aluop = 3'd1; end
            1:  begin v.we = 1; v.alusrc = 1; v.aluop = 3'd1; v.nemux = 1; end
            2:  begin v.we = 1; v.alusrc = 1; v.aluop = 3'd2; end
            3:  begin v.we = 1; v.alusrc = 1; v.aluop = 3'd3; end
            4:  begin v.we = 1; v.alusrc = 1; end
            5:  v.we = 1;
            6:  v.jump = 1;
            7:  begin v.branch = 1; v.alusrc = 1; v.aluop = 3'd1; v.nemux = 1; end
            8:  begin v.memread = 1; v.alusrc = 1; end
            9:  v.memread = 1;
            10: begin v.memwrite = 1; v.alusrc = 1; end
            11: v.memwrite = 1;
            12: begin v.alusrc = 1; v.aluop = 3'd4; end
            13: begin v.bne = 1; v.alusrc = 1; v.aluop = 3'd1; v.nemux = 1; end
            14: begin v.we = 1; v.aluop = 3'd5; end
            default: begin v.we = 1; v.aluop = 3'd5; v.shdir = 1; end
        endcase
        return v;
    endfunction

    function automatic logic [OW-1:0] rop();
        return OW'($urandom_range(0, 1023));
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Drive inputs for the next rising edge and queue what the outputs must be after it.
    task automatic step(input logic [OW-1:0] op, input logic iv, input logic bw, input vec_t e);
        @(negedge CLK);
        #1;
        OPCODE = op; INSTR_VALID = iv; BUSYWAIT = bw;
        expq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(rop(), 1'b0, rb(), '0);
    endtask

    // One instruction at transaction level; stalls carry random INSTR_VALID noise that must be ignored.
    task automatic run_instr(input logic [OW-1:0] op, input int nbusy);
        vec_t d, e;
        d = dec(op);
        e = d;
        if (d.illegal) begin
            step(op, 1'b1, rb(), d);
        end else if (op == 12) begin
            if (MC > 1) begin
                e.stall = 1;
                step(op, 1'b1, rb(), e);
                for (int n = 1; n < MC - 1; n++) step(rop(), rb(), rb(), e);
                e.stall = 0; e.we = 1;
                step(rop(), rb(), rb(), e);
            end else begin
                e.we = 1;
                step(op, 1'b1, rb(), e);
            end
        end else if (d.memread || d.memwrite) begin
            e.stall = 1;
            step(op, 1'b1, rb(), e);
            for (int n = 1; n <= nbusy; n++) begin
`ifdef CU_BUSY_TIMEOUT_EN
                if (n == BT) begin
                    e = '0; e.fault = 1;
                    step(rop(), rb(), 1'b1, e);
                    return;
                end
`endif
                step(rop(), rb(), 1'b1, e);
            end
            e = '0;
            if (d.memread) begin e.we = 1; e.mem2reg = 1; end
            step(rop(), rb(), 1'b0, e);
            if (d.memread) step(rop(), rb(), rb(), '0);
        end else begin
            step(op, 1'b1, rb(), d);
        end
    endtask

    always begin
        vec_t w;
        @(posedge CLK);
        #2;
        if (expq.size() > 0) begin
            w = expq.pop_front();
            chk("ctl", actual(), w);
        end
    end

    initial begin
        vec_t z;
        z = '0;
        RESET = 1'b1; OPCODE = '0; INSTR_VALID = 1'b0; BUSYWAIT = 1'b0;
        #12;
        chk("reset_state", actual(), z);
        @(negedge CLK); #1 RESET = 1'b0;

        // Asynchronous reset in the second cycle of a mult.
        step(OW'(12), 1'b1, 1'b0, '{alusrc: 1, aluop: 3'd4, stall: 1, default: 0});
        step(OW'(3), 1'b1, 1'b0, '{alusrc: 1, aluop: 3'd4, stall: 1, default: 0});
        @(posedge CLK); #3;
        RESET = 1'b1; INSTR_VALID = 1'b0;
        #1;
        chk("reset_mid_mult", actual(), z);
        @(negedge CLK); @(negedge CLK); #1 RESET = 1'b0;
        chk("reset_held", actual(), z);
        run_instr(OW'(12), 0);
        idle(1);

        run_instr(OW'(0), 0);
        run_instr(OW'(7), 0);
        idle(1);
        run_instr(OW'(12), 0);
        run_instr(OW'(8), 4);
        run_instr(OW'(11), 0);
        run_instr(OW'(10'h1F), 0);
        run_instr(OW'(10'h100), 0);
        run_instr(OW'(13), 0);
        run_instr(OW'(14), 0);
        run_instr(OW'(15), 0);
        run_instr(OW'(9), BT + 2);
        idle(2);

        for (int t = 0; t < 300; t++) begin
            logic [OW-1:0] op;
            op = ($urandom_range(0, 9) == 0) ? rop() : OW'($urandom_range(0, 15));
            run_instr(op, ($urandom_range(0, 5) == 0) ? $urandom_range(0, BT + 3) : $urandom_range(0, 3));
            idle($urandom_range(0, 2));
        end
        idle(2);
        @(posedge CLK); #4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/control_unit_mc.md
Name: control_unit_mc

Overview:
Multi-cycle successor to the single-cycle opcode decoder for the 8-bit CPU datapath. It sits between instruction fetch and the datapath/register file and decodes an extended ISA (arithmetic, shifts, branches, multiply, data-memory load/store). It sequences multi-cycle MULT and busywait-driven memory accesses through a state machine. It drives STALL to freeze the PC during these operations. All control outputs are registered, which replaces the old fixed #1 decode delay.

Parameters:
OPCODE_W, 8, opcode field width; decode compares the low 8 bits, and any upper bits must be 0 or the opcode is illegal.
MULT_CYCLES, 3, total cycles a MULT occupies the ALU (>=1).
BUSY_TIMEOUT, 255, max cycles BUSYWAIT may stay high; used only with CU_BUSY_TIMEOUT_EN.

Ports:
CLK  input  1  single clock, rising edge.
RESET  input  1  asynchronous, active-high reset.
OPCODE  input  OPCODE_W  opcode of the fetched instruction.
INSTR_VALID  input  1  OPCODE is a new instruction this cycle.
BUSYWAIT  input  1  data memory busy.
WRITEENABLE  output  1  register-file write.
ALUSRC  output  1  1 = register operand, 0 = immediate.
ALUOP  output  3  000 fwd, 001 add, 010 and, 011 or, 100 mult, 101 shift.
NEMUX  output  1  negate operand 2.
SHDIR  output  1  shift direction: 0 = left, 1 = right.
BRANCH  output  1  beq.
BNE  output  1  bne.
JUMP  output  1  unconditional jump.
MEMREAD  output  1  data-memory read request.
MEMWRITE  output  1  data-memory write request.
MEM2REG  output  1  writeback source is memory.
STALL  output  1  freeze PC/fetch.
ILLEGAL  output  1  undefined opcode pulse.

Behaviour:
- Opcode map: 0 add, 1 sub, 2 and, 3 or, 4 mov, 5 loadi, 6 j, 7 beq, 8 lwd, 9 lwi, 10 swd, 11 swi, 12 mult, 13 bne, 14 sll, 15 srl.
- Decode values for 0-7 are unchanged from the existing decoder. sub/beq/bne use ALUOP=001 with NEMUX=1.
- lwi/swi use ALUSRC=0; lwd/swd use ALUSRC=1; both load and store use ALUOP=000.
- Reset, asynchronous: every output is 0, state is READY, the cycle counter is 0, and any in-flight memory request is dropped.
- States: READY, MULT, MEM, WB.
- READY (STALL=0):
  - On a rising edge with INSTR_VALID=1, register the decoded controls. Latency is 1 edge.
  - Single-cycle ops: stay in READY. Outputs are valid for one cycle, then return to 0 at the next edge unless a new INSTR_VALID arrives.
- Entering MULT:
  - Applies to mult when MULT_CYCLES>1.
  - ALUOP=100, WRITEENABLE=0, STALL=1, counter loaded with MULT_CYCLES-1.
- MULT state:
  - Counter decrements each edge.
  - On the edge where it reaches 0: WRITEENABLE=1 and STALL=0 for exactly one cycle, then return to READY.
  - Total occupancy is exactly MULT_CYCLES cycles.
  - When MULT_CYCLES=1, mult behaves as a single-cycle op and STALL never asserts.
- Loads/stores (READY -> MEM):
  - Assert MEMREAD (loads) or MEMWRITE (stores), with STALL=1.
- MEM state:
  - BUSYWAIT is sampled at each edge, starting the edge after the request.
  - While BUSYWAIT=1, hold all outputs.
  - On the first edge with BUSYWAIT=0, clear MEMREAD/MEMWRITE.
  - Loads then go to WB; stores go to READY with STALL=0.
  - A memory that never raises BUSYWAIT completes in 1 cycle.
- WB state:
  - WRITEENABLE=1, MEM2REG=1, STALL=0 for one cycle, then READY.
- INSTR_VALID is ignored whenever STALL=1 or state is not READY.
- Illegal opcode:
  - All enables stay 0, ILLEGAL=1 for one cycle, and the block stays in READY.
  - Upper opcode bits above 8 that are nonzero also count as illegal.
- MEMREAD and MEMWRITE are never asserted together.
- WRITEENABLE is never asserted with MEMWRITE, BRANCH, BNE or JUMP.

Optional Feature:
CU_BUSY_TIMEOUT_EN.
- Defined:
  - An extra output MEM_FAULT (1 bit) exists.
  - A timeout counter runs while in MEM with BUSYWAIT=1.
  - When BUSYWAIT has been high for BUSY_TIMEOUT consecutive sampled edges, abort: clear MEMREAD/MEMWRITE, skip WB, set STALL=0, pulse MEM_FAULT for one cycle, return to READY.
  - MEM_FAULT resets to 0.
- Undefined: no MEM_FAULT port and no counter; the block waits on BUSYWAIT indefinitely.

Test Plan:
- Reset mid-MULT: RESET asserted during cycle 2 of mult -> all outputs 0 immediately, without waiting for CLK; next mult completes normally.
- add (0x00), INSTR_VALID=1 -> next edge WRITEENABLE=1, ALUOP=001, NEMUX=0, ALUSRC=1, STALL=0; beq (0x07) -> BRANCH=1, NEMUX=1, WRITEENABLE=0.
- mult (0x0C) with MULT_CYCLES=3 -> STALL=1 for 2 cycles, WRITEENABLE=1 only in cycle 3; an INSTR_VALID pulse during the stall is ignored.
- lwd (0x08), BUSYWAIT=1 for 4 edges then 0 -> MEMREAD=1 for 5 cycles, then one cycle of WRITEENABLE=1 with MEM2REG=1, then STALL=0.
- swi (0x0B), BUSYWAIT held at 0 -> MEMWRITE=1 for 1 cycle, WRITEENABLE never 1; opcode 0x1F -> ILLEGAL pulse, all enables 0.
- CU_BUSY_TIMEOUT_EN defined, BUSY_TIMEOUT=8, BUSYWAIT stuck at 1 on lwi -> MEM_FAULT pulse after 8 edges, MEMREAD=0, no writeback, READY.
